// File: rtl/bcd_accumulator_pkg.sv
// Shared types for the BCD accumulator: digit type, FSM state codes, digit limit.
// Pure declarations, no logic or latency.
package bcd_accumulator_pkg;

    localparam int BCD_MAX = 9;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD0 = 2'd1;
    localparam state_t ST_ADD1 = 2'd2;
    localparam state_t ST_ADD2 = 2'd3;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_accumulator_if.sv
// Operand/control and result bundle of the BCD accumulator.
// Level signals only; no handshake, requests are dropped while busy.
interface bcd_accumulator_if;
    import bcd_accumulator_pkg::*;

    logic       enter;
    logic       clear;
    bcd_digit_t a1;
    bcd_digit_t a0;
    bcd_digit_t d2;
    bcd_digit_t d1;
    bcd_digit_t d0;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       invalid;

    modport master (
        output enter, clear, a1, a0,
        input  d2, d1, d0, busy, done, overflow, invalid
    );

    modport slave (
        input  enter, clear, a1, a0,
        output d2, d1, d0, busy, done, overflow, invalid
    );

endinterface

// File: rtl/bcd_accumulator_digit_add.sv
// One BCD digit adder with carry-in and +6 decimal correction.
// Purely combinational, no backpressure.
module bcd_digit_add
    import bcd_accumulator_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        adj  = raw + 5'd6;
        cout = raw > 5'(BCD_MAX);
        sum  = cout ? adj[3:0] : raw[3:0];
    end

endmodule

// File: rtl/bcd_accumulator.sv
// Three-digit BCD running total; a debounced Enter edge adds a two-digit operand.
// Done 4 cycles after the detected edge; requests while busy are dropped, not queued.
module bcd_accumulator
    import bcd_accumulator_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    bcd_accumulator_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   enter_s;
    logic                   req;

    state_t     state_q;
    bcd_digit_t op1_q, op0_q;
    bcd_digit_t d2_q, d1_q, d0_q;
    logic       carry_q;
    logic       done_q;
    logic       ovf_q;
    logic       inv_q;

    bcd_digit_t add_a, add_b, add_sum;
    logic       add_cin, add_cout;

    assign enter_s = sync_q[SYNC_STAGES-1];

    // Only arm the edge detector once a real low has emerged from a filled
    // synchroniser, so a button held through reset never fires.
    assign req = armed_q & enter_s & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q[0] <= bus.enter;
            fill_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
                fill_q[i] <= fill_q[i-1];
            end
            prev_q <= enter_s;
            if (fill_q[SYNC_STAGES-1] && !enter_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_ADD0: begin
                add_a = d0_q;
                add_b = op0_q;
            end
            ST_ADD1: begin
                add_a   = d1_q;
                add_b   = op1_q;
                add_cin = carry_q;
            end
            ST_ADD2: begin
                add_a   = d2_q;
                add_cin = carry_q;
            end
            default: begin
            end
        endcase
    end

    bcd_digit_add u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op1_q   <= '0;
            op0_q   <= '0;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state_q <= ST_IDLE;
                d2_q    <= '0;
                d1_q    <= '0;
                d0_q    <= '0;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
                inv_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req) begin
                            if (!is_bcd(bus.a1) || !is_bcd(bus.a0)) begin
                                inv_q <= 1'b1;
                            end else begin
                                inv_q   <= 1'b0;
                                op1_q   <= bus.a1;
                                op0_q   <= bus.a0;
                                state_q <= ST_ADD0;
                            end
                        end
                    end
                    ST_ADD0: begin
                        d0_q    <= add_sum;
                        carry_q <= add_cout;
                        state_q <= ST_ADD1;
                    end
                    ST_ADD1: begin
                        d1_q    <= add_sum;
                        carry_q <= add_cout;
                        state_q <= ST_ADD2;
                    end
                    ST_ADD2: begin
                        d2_q    <= add_sum;
                        carry_q <= 1'b0;
                        if (add_cout) begin
                            ovf_q <= 1'b1;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.d2       = d2_q;
    assign bus.d1       = d1_q;
    assign bus.d0       = d0_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;

endmodule

// File: doc/bcd_accumulator.md
BCD_ACCUMULATOR -- requirements
Module: bcd_accumulator

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages synchronising Enter.
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Enter  input  1  asynchronous pushbutton level; a rising edge requests one accumulate operation.
REQ-005 Clear  input  1  synchronous, active-high request to zero the running total.
REQ-006 A1  input  4  BCD tens digit of the operand.
REQ-007 A0  input  4  BCD units digit of the operand.
REQ-008 D2  output  4  BCD hundreds digit of the running total.
REQ-009 D1  output  4  BCD tens digit of the running total.
REQ-010 D0  output  4  BCD units digit of the running total.
REQ-011 Busy  output  1  high while the FSM is not in IDLE.
REQ-012 Done  output  1  one-cycle pulse when an accumulate completes.
REQ-013 Overflow  output  1  sticky flag; a sum exceeded 999.
REQ-014 Invalid  output  1  sticky flag; the last request had a non-BCD operand digit.

Function
REQ-015 Enter shall pass through SYNC_STAGES flops; a rising-edge detect on the synchronised signal gives a one-cycle request in cycle E.
REQ-016 A request in IDLE shall capture A1 and A0 in cycle E; later changes to A1 and A0 shall not affect the operation.
REQ-017 If either captured digit is greater than 9, the block shall set Invalid, leave D2..D0 unchanged, stay in IDLE, and not pulse Done.
REQ-018 A valid request shall clear Invalid and move the FSM IDLE -> ADD0 (E+1) -> ADD1 (E+2) -> ADD2 (E+3) -> IDLE (E+4).
REQ-019 ADD0 shall set D0 to (D0 + A0) mod 10 and set an internal carry when the sum is 10 or more.
REQ-020 ADD1 shall do the same for D1 and A1 plus the carry.
REQ-021 ADD2 shall set D2 to (D2 + carry) mod 10.
REQ-022 A carry out of ADD2 shall set Overflow, so the total wraps modulo 1000.
REQ-023 Done shall be high only in cycle E+4, with the final digits already visible on D2..D0.
REQ-024 Busy shall be high in cycles E+1 through E+3.
REQ-025 Requests arriving while Busy shall be ignored and shall not be queued.
REQ-026 Clear shall zero D2..D0, Overflow and Invalid on the next edge, return the FSM to IDLE, and abort any operation in progress without a Done pulse.
REQ-027 Clear in the same cycle as a request shall win; the request shall be discarded.
REQ-028 Outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-029 Reset shall immediately force D2=D1=D0=0, Busy=0, Done=0, Overflow=0 and Invalid=0, the FSM to IDLE, and the synchroniser and edge-detect flops to 0.
REQ-030 Assertion of Reset mid-operation shall abandon the operation with no Done pulse.
REQ-031 After Reset deasserts, the first request shall be recognised only on a genuine 0->1 transition of synchronised Enter; a button held through reset shall not trigger an operation.

Structure
REQ-032 A shared package shall hold the FSM state enumeration (IDLE, ADD0, ADD1, ADD2), the constant BCD_MAX = 9, and the 4-bit BCD digit type.
REQ-033 A combinational sub-module bcd_digit_add shall compute one digit sum with carry-in, giving a 4-bit digit and a carry-out with +6 correction, and shall be used by every ADD state.

Verification
REQ-034 Reset, then Clear, then a request with A1=4, A0=7 -> D=047, Done pulses exactly 4 cycles after the detected edge, Busy is high for 3 cycles.
REQ-035 From total 047, a request with A1=5, A0=8 -> D=105, Overflow=0.
REQ-036 From total 990, a request with A1=1, A0=5 -> D=005, Overflow=1; it stays 1 after a further request of 01 (D=006).
REQ-037 A request with A0=0xB -> Invalid=1, digits unchanged, no Done; a next valid request of 02 -> Invalid=0 and the total increases by 2.
REQ-038 A second Enter edge during Busy -> ignored, so only one Done pulse and one addition occur; Clear asserted in cycle E+2 -> D=000 next cycle, Busy=0, no Done.
REQ-039 Reset asserted in ADD1 -> all outputs 0 immediately; Enter held high through reset release -> no operation starts until Enter goes low then high.
